// File: rtl/steering_link_if.sv
// Steering link receive-side bundle: async link pins in, qualified
// angle/pulse/error outputs back to the steering actuator logic.
interface steering_link_if #(
    parameter int DATA_W = 9
);
    logic [DATA_W-1:0] link_data;
    logic              link_reset_pos;
    logic              clear_errors;
    logic [DATA_W-1:0] angle;
    logic              angle_valid;
    logic              range_error;
    logic              reset_pos_req;
    logic [7:0]        error_count;

    modport master (
        output link_data,
        output link_reset_pos,
        output clear_errors,
        input  angle,
        input  angle_valid,
        input  range_error,
        input  reset_pos_req,
        input  error_count
    );

    modport slave (
        input  link_data,
        input  link_reset_pos,
        input  clear_errors,
        output angle,
        output angle_valid,
        output range_error,
        output reset_pos_req,
        output error_count
    );
endinterface

// File: rtl/steering_link_rx.sv
// Steering link receiver: synchronizes the link pins, filters the word for
// stability, range-checks it and qualifies reset-position requests.
module steering_link_rx #(
    parameter int DATA_W         = 9,
    parameter int STABLE_CYCLES  = 1000,
    parameter int MAX_ANGLE      = 359,
    parameter int RST_MIN_CYCLES = 50000
) (
    input logic             CLOCK_50,
    input logic             reset_n,
    steering_link_if.slave  lnk
);
    localparam int CW = $clog2(STABLE_CYCLES);
    localparam int RW = $clog2(RST_MIN_CYCLES);
    localparam logic [CW-1:0]     CNT_MAX   = CW'(STABLE_CYCLES - 1);
    localparam logic [RW-1:0]     RCNT_MAX  = RW'(RST_MIN_CYCLES - 1);
    localparam logic [RW-1:0]     RCNT_ONE  = RW'(1);
    localparam logic [DATA_W-1:0] ANGLE_MAX = DATA_W'(MAX_ANGLE);

    typedef enum logic [1:0] {
        RS_IDLE,
        RS_ARMING,
        RS_FIRED
    } rs_state_e;

    logic [DATA_W:0]   sync1_q, sync1_d;
    logic [DATA_W:0]   sync2_q, sync2_d;
    logic [DATA_W-1:0] cand_q, cand_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              judged_q, judged_d;
    rs_state_e         rs_q, rs_d;
    logic [RW-1:0]     rcnt_q, rcnt_d;
    logic [DATA_W-1:0] angle_q, angle_d;
    logic              angle_valid_q, angle_valid_d;
    logic              range_error_q, range_error_d;
    logic              reset_pos_req_q, reset_pos_req_d;
    logic [7:0]        err_cnt_q, err_cnt_d;

    logic [DATA_W-1:0] word;
    logic              rpos;
    logic              judge;
    logic              fire;
    logic              in_range;

    always_comb begin
        sync1_d  = {lnk.link_reset_pos, lnk.link_data};
        sync2_d  = sync1_q;
        word     = sync2_q[DATA_W-1:0];
        rpos     = sync2_q[DATA_W];
        in_range = (word <= ANGLE_MAX);

        cand_d   = cand_q;
        cnt_d    = cnt_q;
        judged_d = judged_q;
        judge    = 1'b0;
        if (word != cand_q) begin
            cand_d   = word;
            cnt_d    = '0;
            judged_d = 1'b0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!judged_q) begin
            judge    = 1'b1;
            judged_d = 1'b1;
        end

        rs_d   = rs_q;
        rcnt_d = rcnt_q;
        fire   = 1'b0;
        case (rs_q)
            RS_IDLE: begin
                if (rpos) begin
                    rs_d   = RS_ARMING;
                    rcnt_d = RCNT_ONE;
                end
            end
            RS_ARMING: begin
                if (!rpos) begin
                    rs_d = RS_IDLE;
                end else if (rcnt_q == RCNT_MAX) begin
                    rs_d = RS_FIRED;
                    fire = 1'b1;
                end else begin
                    rcnt_d = rcnt_q + 1'b1;
                end
            end
            RS_FIRED: begin
                if (!rpos) rs_d = RS_IDLE;
            end
            default: rs_d = RS_IDLE;
        endcase

        angle_d         = angle_q;
        angle_valid_d   = 1'b0;
        range_error_d   = 1'b0;
        reset_pos_req_d = fire;
        err_cnt_d       = err_cnt_q;
        if (judge && !in_range) begin
            range_error_d = 1'b1;
            if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
        end
        // A reset-position fire overrides a word accepted on the same edge
        if (fire) begin
            angle_d = '0;
        end else if (judge && in_range && word != angle_q) begin
            angle_d       = word;
            angle_valid_d = 1'b1;
        end
        if (lnk.clear_errors) err_cnt_d = '0;
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q         <= '0;
            sync2_q         <= '0;
            cand_q          <= '0;
            cnt_q           <= '0;
            judged_q        <= 1'b1;
            rs_q            <= RS_IDLE;
            rcnt_q          <= '0;
            angle_q         <= '0;
            angle_valid_q   <= 1'b0;
            range_error_q   <= 1'b0;
            reset_pos_req_q <= 1'b0;
            err_cnt_q       <= '0;
        end else begin
            sync1_q         <= sync1_d;
            sync2_q         <= sync2_d;
            cand_q          <= cand_d;
            cnt_q           <= cnt_d;
            judged_q        <= judged_d;
            rs_q            <= rs_d;
            rcnt_q          <= rcnt_d;
            angle_q         <= angle_d;
            angle_valid_q   <= angle_valid_d;
            range_error_q   <= range_error_d;
            reset_pos_req_q <= reset_pos_req_d;
            err_cnt_q       <= err_cnt_d;
        end
    end

    assign lnk.angle         = angle_q;
    assign lnk.angle_valid   = angle_valid_q;
    assign lnk.range_error   = range_error_q;
    assign lnk.reset_pos_req = reset_pos_req_q;
    assign lnk.error_count   = err_cnt_q;
endmodule
